// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer
// On each accepted sample trigger, converts every enabled channel of an 8:1 SPI ADC
// in one continuous burst of N+1 16-bit frames. Each result is streamed as an
// Avalon-ST word carrying its channel index, SOP/EOP markers and error flags.
// SCLK is generated internally from clk and idles high.

module adc_spi_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int CLK_DIV      = 2,
    parameter int CH_W         = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    output logic                    sclk,
    output logic                    cs_n,
    output logic                    mosi,
    input  logic                    miso,
    output logic [DATA_WIDTH-1:0]   ast_source_data,
    output logic [CH_W-1:0]         ast_source_channel,
    output logic                    ast_source_valid,
    output logic                    ast_source_startofpacket,
    output logic                    ast_source_endofpacket,
    output logic [1:0]              ast_source_error,
    output logic                    busy
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sclk;
    logic                    r_csN;
    logic                    r_mosi;
    logic                    r_busy;
    logic [3:0]              r_bit;
    logic [3:0]              r_frame;
    logic [3:0]              r_numCh;
    logic [NUM_CHANNELS-1:0] r_remaining;
    logic [CH_W-1:0]         r_firstAddr;
    logic [CH_W-1:0]         r_curAddr;
    logic [CH_W-1:0]         r_prevAddr;
    logic [15:0]             r_shift;
    logic                    r_pend;
    logic                    r_ovrFlag;
    logic                    r_ovrBurst;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [CH_W-1:0]         r_chan;
    logic                    r_valid;
    logic                    r_sop;
    logic                    r_eop;
    logic [1:0]              r_err;

    logic                    w_accept;
    logic                    w_fall;
    logic                    w_rise;
    logic                    w_release;
    logic                    w_cntDone;
    logic                    w_newFrame;
    logic [3:0]              w_nextBit;
    logic [CH_W-1:0]         w_remLowest;
    logic [CH_W-1:0]         w_nextAddr;
    logic [NUM_CHANNELS-1:0] w_nextRemaining;
    logic                    w_mosiNext;
    logic [15:0]             w_lead;

    function automatic logic [CH_W-1:0] lowestSet(input logic [NUM_CHANNELS-1:0] m);
        lowestSet = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) lowestSet = CH_W'(i);
        end
    endfunction

    function automatic logic [3:0] popCount(input logic [NUM_CHANNELS-1:0] m);
        popCount = 4'd0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            popCount = popCount + 4'(m[i]);
        end
    endfunction

    assign w_cntDone       = (r_cnt == CNT_LAST);
    assign w_newFrame      = w_fall && ((r_state == SETUP) || (r_bit == 4'd15));
    assign w_nextBit       = r_bit + 4'd1;
    assign w_remLowest     = lowestSet(r_remaining);
    assign w_nextAddr      = (r_remaining != '0) ? w_remLowest : r_firstAddr;
    assign w_nextRemaining = r_remaining & ~(NUM_CHANNELS'(1) << w_remLowest);
    assign w_mosiNext      = (w_nextBit == 4'd2) ? r_curAddr[2] :
                             (w_nextBit == 4'd3) ? r_curAddr[1] :
                             (w_nextBit == 4'd4) ? r_curAddr[0] : 1'b0;
    assign w_lead          = r_shift >> DATA_WIDTH;

    // State register; reset aborts any burst in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic and the SCLK edge / trigger / release strobes for the datapath.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_fall      = 1'b0;
        w_rise      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample && (chan_mask != '0)) begin
                    w_accept    = 1'b1;
                    w_nextState = SETUP;
                end
            end
            SETUP: begin
                if (w_cntDone) begin
                    w_fall      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cntDone) begin
                    if (!r_sclk) begin
                        w_rise = 1'b1;
                        if ((r_bit == 4'd15) && (r_frame == r_numCh)) w_nextState = HOLD;
                    end else begin
                        w_fall = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_cntDone) begin
                    w_release   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Half-period counter, restarted on every SCLK edge and state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      r_cnt <= '0;
        else if (w_accept || w_fall || w_rise || w_release) r_cnt <= '0;
        else if (r_state != IDLE)                       r_cnt <= r_cnt + 1'b1;
    end

    // SPI side: chip select, SCLK, MOSI address bits and the per-frame channel walk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk      <= 1'b1;
            r_csN       <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_bit       <= 4'd0;
            r_frame     <= 4'd0;
            r_numCh     <= 4'd0;
            r_remaining <= '0;
            r_firstAddr <= '0;
            r_curAddr   <= '0;
            r_prevAddr  <= '0;
        end else begin
            if (w_accept) begin
                r_csN       <= 1'b0;
                r_busy      <= 1'b1;
                r_numCh     <= popCount(chan_mask);
                r_remaining <= chan_mask;
                r_firstAddr <= lowestSet(chan_mask);
                r_bit       <= 4'd0;
                r_frame     <= 4'd0;
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (w_newFrame) begin
                    r_bit       <= 4'd0;
                    r_mosi      <= 1'b0;
                    r_prevAddr  <= r_curAddr;
                    r_curAddr   <= w_nextAddr;
                    r_remaining <= w_nextRemaining;
                    if (r_state == SHIFT) r_frame <= r_frame + 4'd1;
                end else begin
                    r_bit  <= w_nextBit;
                    r_mosi <= w_mosiNext;
                end
            end
            if (w_rise) r_sclk <= 1'b1;
            if (w_release) begin
                r_csN  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    // MISO shift register; flags a completed word at the end of every frame after the first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= 16'd0;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= w_rise && (r_bit == 4'd15) && (r_frame != 4'd0);
            if (w_rise) r_shift <= {r_shift[14:0], miso};
        end
    end

    // Overrun: a trigger while busy is remembered and handed to the next burst's first word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovrFlag  <= 1'b0;
            r_ovrBurst <= 1'b0;
        end else if (w_accept) begin
            r_ovrBurst <= r_ovrFlag;
            r_ovrFlag  <= 1'b0;
        end else if (sample && r_busy) begin
            r_ovrFlag <= 1'b1;
        end
    end

    // Avalon-ST source: one-clock valid, payload held until the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_valid <= r_pend;
            if (r_pend) begin
                r_data <= r_shift[DATA_WIDTH-1:0];
                r_chan <= r_prevAddr;
                r_sop  <= (r_frame == 4'd1);
                r_eop  <= (r_frame == r_numCh);
                r_err  <= {(w_lead != 16'd0), r_ovrBurst && (r_frame == 4'd1)};
            end
        end
    end

    assign sclk                     = r_sclk;
    assign cs_n                     = r_csN;
    assign mosi                     = r_mosi;
    assign busy                     = r_busy;
    assign ast_source_data          = r_data;
    assign ast_source_channel       = r_chan;
    assign ast_source_valid         = r_valid;
    assign ast_source_startofpacket = r_sop;
    assign ast_source_endofpacket   = r_eop;
    assign ast_source_error         = r_err;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer
// Drives bursts through adc_spi_sequencer against a behavioural ADC that decodes the
// MOSI address and answers with 12'hA00+channel one frame later. Expected words and
// MOSI addresses are queued when a trigger is issued and compared as they appear.

module tb_adc_spi_sequencer;

    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int CD  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           sample;
    logic [NCH-1:0] chanMask;
    logic           sclk;
    logic           cs_n;
    logic           mosi;
    logic           miso;
    logic [DW-1:0]  data;
    logic [2:0]     channel;
    logic           valid;
    logic           sop;
    logic           eop;
    logic [1:0]     err;
    logic           busy;

    typedef struct {
        logic [3:0] mask;
        int         faultCh;
        bit         extraTrig;
        int         expFrames;
        int         expCsRise;
    } vector_t;

    typedef struct {
        logic [18:0] tuple;
        int          rel;
    } word_t;

    word_t       expWords[$];
    logic [2:0]  expAddr[$];
    vector_t     vectors[7];

    int          nChecks  = 0;
    int          nFails   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    int          faultCh  = -1;
    bit          pendOvr  = 1'b0;
    int          frameCnt = 0;

    logic        prevSclk = 1'b1;
    logic        prevCs   = 1'b1;
    int          k        = 0;
    logic [15:0] adcWord  = 16'hFFFF;
    logic [2:0]  addrSh   = 3'd0;
    logic [2:0]  lastAddr = 3'd0;

    adc_spi_sequencer #(
        .NUM_CHANNELS(NCH),
        .DATA_WIDTH  (DW),
        .CLK_DIV     (CD),
        .CH_W        (3)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .sample                  (sample),
        .chan_mask               (chanMask),
        .sclk                    (sclk),
        .cs_n                    (cs_n),
        .mosi                    (mosi),
        .miso                    (miso),
        .ast_source_data         (data),
        .ast_source_channel      (channel),
        .ast_source_valid        (valid),
        .ast_source_startofpacket(sop),
        .ast_source_endofpacket  (eop),
        .ast_source_error        (err),
        .busy                    (busy)
    );

    // Free-running system clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic reportUnexpected(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: actual event present required none (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] makeWord(input logic [2:0] addr);
        logic [15:0] w;
        w = {4'b0000, 12'hA00 + 12'(addr)};
        if (int'(addr) == faultCh) w[15] = 1'b1;
        return w;
    endfunction

    // ADC model: drives DOUT after each SCLK fall, reads DIN on each SCLK rise.
    task automatic modelStep();
        int b;
        if (!cs_n) begin
            if (prevCs) k = 0;
            if (prevSclk && !sclk) begin
                if ((k % 16) == 0) adcWord = (k == 0) ? 16'hFFFF : makeWord(lastAddr);
                miso = adcWord[4'(15 - (k % 16))];
                k++;
            end else if (!prevSclk && sclk) begin
                b = (k - 1) % 16;
                if (b >= 2 && b <= 4) addrSh = {addrSh[1:0], mosi};
                if (b == 15) begin
                    lastAddr = addrSh;
                    frameCnt++;
                    if (expAddr.size() == 0) reportUnexpected("mosi_addr_extra_frame");
                    else checkOutput("mosi_addr", 32'(addrSh), 32'(expAddr.pop_front()));
                end
            end
        end
        prevSclk = sclk;
        prevCs   = cs_n;
    endtask

    task automatic monitorStep();
        word_t w;
        if (valid) begin
            if (expWords.size() == 0) begin
                reportUnexpected("valid_unexpected");
            end else begin
                w = expWords.pop_front();
                checkOutput("word_payload", 32'({data, channel, sop, eop, err}), 32'(w.tuple));
                checkOutput("word_time", 32'(cyc - t0), 32'(w.rel));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        modelStep();
        monitorStep();
    endtask

    task automatic pushExpect(input logic [3:0] mask);
        int n;
        int idx;
        int first;
        word_t w;
        n     = $countones(mask);
        idx   = 0;
        first = -1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                if (first < 0) first = ch;
                w.tuple = {12'hA00 + 12'(ch), 3'(ch), (idx == 0), (idx == n - 1),
                           (ch == faultCh), (idx == 0) && pendOvr};
                w.rel   = 32 * CD * (idx + 2) + 1;
                expWords.push_back(w);
                expAddr.push_back(3'(ch));
                idx++;
            end
        end
        expAddr.push_back(3'(first));
        pendOvr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] mask);
        chanMask = mask;
        sample   = 1'b1;
        tick();
        t0       = cyc;
        sample   = 1'b0;
        chanMask = 4'($urandom);
    endtask

    task automatic runVector(input vector_t v);
        bit active;
        faultCh  = v.faultCh;
        frameCnt = 0;
        if (v.mask != 4'd0) pushExpect(v.mask);
        applyStimulus(v.mask);
        if (v.mask == 4'd0) begin
            active = 1'b0;
            repeat (40) begin
                tick();
                if (!cs_n || busy) active = 1'b1;
            end
            checkOutput("idle_activity", 32'(active), 32'd0);
            checkOutput("idle_frames", 32'(frameCnt), 32'd0);
        end else begin
            while (!cs_n && (cyc - t0) < 2000) begin
                tick();
                if (sample) sample = 1'b0;
                if (v.extraTrig && (cyc - t0) == 10) begin
                    checkOutput("busy_mid_burst", 32'(busy), 32'd1);
                    sample = 1'b1;
                end
            end
            sample = 1'b0;
            checkOutput("cs_rise_time", 32'(cyc - t0), 32'(v.expCsRise));
            checkOutput("busy_low_at_cs_rise", 32'(busy), 32'd0);
            checkOutput("frame_count", 32'(frameCnt), 32'(v.expFrames));
            checkOutput("words_outstanding", 32'(expWords.size()), 32'd0);
            if (v.extraTrig) pendOvr = 1'b1;
        end
        repeat (3) tick();
    endtask

    initial begin
        vectors[0] = '{4'b0101, -1, 1'b0, 3, 194};
        vectors[1] = '{4'b1000, -1, 1'b0, 2, 130};
        vectors[2] = '{4'b1111, -1, 1'b0, 5, 322};
        vectors[3] = '{4'b0111, -1, 1'b1, 4, 258};
        vectors[4] = '{4'b0110,  1, 1'b0, 3, 194};
        vectors[5] = '{4'b0011,  1, 1'b0, 3, 194};
        vectors[6] = '{4'b0000, -1, 1'b0, 0, 0};

        reset    = 1'b1;
        sample   = 1'b0;
        chanMask = 4'd0;
        miso     = 1'b0;
        repeat (3) tick();
        checkOutput("reset_state",
                    32'({cs_n, sclk, mosi, busy, valid, sop, eop, err, channel, data}),
                    32'h00C00000);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            runVector(vectors[i]);
        end

        checkOutput("payload_hold",
                    32'({valid, data, channel, sop, eop, err}),
                    32'({1'b0, 12'hA01, 3'd1, 1'b0, 1'b1, 2'b10}));

        faultCh  = -1;
        frameCnt = 0;
        pushExpect(4'b0101);
        applyStimulus(4'b0101);
        while ((cyc - t0) < 69) tick();
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_burst",
                    32'({cs_n, sclk, mosi, busy, valid, sop, eop, err, channel, data}),
                    32'h00C00000);
        expWords.delete();
        expAddr.delete();
        repeat (5) tick();
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("reset_mid_frames_done", 32'(frameCnt), 32'd1);
        runVector('{4'b0101, -1, 1'b0, 3, 194});

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
